ov7670_capture: RTL

Pixel-capture stage downstream of the OV7670 SCCB configuration block. It waits for `Config_Done`, discards a fixed number of settling frames, and then assembles the sensor's 8-bit DVP byte stream into 16-bit RGB565 pixels. Each pixel is emitted with valid, position and frame/line markers for the frame-buffer writer. The block runs entirely in the camera pixel-clock domain.

---
 rtl/ov7670_pkg.sv | 14 +
 rtl/ov7670_capture_dvp_sync_edge.sv | 42 ++++
 rtl/ov7670_capture.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ov7670_pkg.sv
// Shared state encoding and default geometry for the OV7670 capture path.
package ov7670_pkg;
  typedef enum logic [1:0] {
    ST_WAIT_CFG   = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_SKIP       = 2'd2,
    ST_CAPTURE    = 2'd3
  } cap_state_e;

  localparam int H_ACTIVE_DEF   = 640;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int FRAME_SKIP_DEF = 10;
  localparam int COORD_W        = 10;
endpackage

// File: rtl/ov7670_capture_dvp_sync_edge.sv
// Registers the raw DVP inputs once (VSYNC/HREF twice) and derives edge pulses.
module dvp_sync_edge (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic [7:0] data_i,
  output logic       vsync_o,
  output logic       href_o,
  output logic [7:0] data_o,
  output logic       vs_rise_o,
  output logic       vs_fall_o,
  output logic       href_rise_o,
  output logic       href_fall_o
);
  logic       vs_r1_q, vs_r2_q, href_r1_q, href_r2_q;
  logic [7:0] data_r1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs_r1_q   <= 1'b0;
      vs_r2_q   <= 1'b0;
      href_r1_q <= 1'b0;
      href_r2_q <= 1'b0;
      data_r1_q <= '0;
    end else begin
      vs_r1_q   <= vsync_i;
      vs_r2_q   <= vs_r1_q;
      href_r1_q <= href_i;
      href_r2_q <= href_r1_q;
      data_r1_q <= data_i;
    end
  end

  assign vsync_o     = vs_r1_q;
  assign href_o      = href_r1_q;
  assign data_o      = data_r1_q;
  assign vs_rise_o   = vs_r1_q & ~vs_r2_q;
  assign vs_fall_o   = vs_r2_q & ~vs_r1_q;
  assign href_rise_o = href_r1_q & ~href_r2_q;
  assign href_fall_o = href_r2_q & ~href_r1_q;
endmodule

// File: rtl/ov7670_capture.sv
// Waits for sensor configuration, skips settling frames, then pairs DVP bytes
// into RGB565 pixels tagged with position and frame/line markers.
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int FRAME_SKIP = FRAME_SKIP_DEF
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iCFG_DONE,
  input  logic               iCMOS_VSYNC,
  input  logic               iCMOS_HREF,
  input  logic [7:0]         iCMOS_DATA,
  output logic [15:0]        oPIX_DATA,
  output logic               oPIX_VALID,
  output logic [COORD_W-1:0] oX,
  output logic [COORD_W-1:0] oY,
  output logic               oFRAME_START,
  output logic               oLINE_END,
  output logic               oFRAME_ERR,
  output logic [7:0]         oFRAME_CNT
);
  localparam int            CW       = COORD_W + 1;
  localparam logic [CW-1:0] H_MAX    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_LAST   = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_MAX    = CW'(V_ACTIVE);
  localparam logic [7:0]    SKIP_MAX = 8'(FRAME_SKIP);

  logic       vsync_r1, href_r1, vs_rise, vs_fall, href_rise, href_fall;
  logic [7:0] data_r1;

  dvp_sync_edge u_sync (
    .clk_i       (iCLK),
    .rst_ni      (iRST_N),
    .vsync_i     (iCMOS_VSYNC),
    .href_i      (iCMOS_HREF),
    .data_i      (iCMOS_DATA),
    .vsync_o     (vsync_r1),
    .href_o      (href_r1),
    .data_o      (data_r1),
    .vs_rise_o   (vs_rise),
    .vs_fall_o   (vs_fall),
    .href_rise_o (href_rise),
    .href_fall_o (href_fall)
  );

  cap_state_e         state_q, state_d;
  logic [7:0]         skip_q, skip_d, fcnt_q, fcnt_d, hi_byte_q, hi_byte_d;
  logic               vs_seen_q, vs_seen_d, hi_pend_q, hi_pend_d;
  logic [CW-1:0]      px_q, px_d, ln_q, ln_d;
  logic [15:0]        pix_q, pix_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               valid_q, valid_d, fs_q, fs_d, le_q, le_d, err_q, err_d;

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    vs_seen_d = vs_seen_q | vsync_r1;
    px_d      = px_q;
    ln_d      = ln_q;
    hi_pend_d = hi_pend_q;
    hi_byte_d = hi_byte_q;
    pix_d     = pix_q;
    x_d       = x_q;
    y_d       = y_q;
    valid_d   = 1'b0;
    fs_d      = 1'b0;
    le_d      = 1'b0;
    err_d     = err_q;
    fcnt_d    = fcnt_q;
    case (state_q)
      ST_WAIT_CFG: begin
        // Forget any VSYNC seen before configuration so a frame already in
        // progress is never picked up halfway.
        vs_seen_d = 1'b0;
        if (iCFG_DONE) state_d = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (vs_fall && vs_seen_q) begin
          if (skip_q < SKIP_MAX) begin
            state_d = ST_SKIP;
          end else begin
            state_d   = ST_CAPTURE;
            err_d     = 1'b0;
            px_d      = '0;
            ln_d      = '0;
            hi_pend_d = 1'b0;
          end
        end
      end
      ST_SKIP: begin
        if (vs_rise) begin
          skip_d  = skip_q + 8'd1;
          state_d = ST_WAIT_FRAME;
        end
      end
      ST_CAPTURE: begin
        if (vs_rise) begin
          state_d = ST_WAIT_FRAME;
          fcnt_d  = fcnt_q + 8'd1;
          if (href_r1 || ln_q != V_MAX) err_d = 1'b1;
        end else if (href_fall) begin
          if (hi_pend_q || (ln_q < V_MAX && px_q != H_MAX)) err_d = 1'b1;
          hi_pend_d = 1'b0;
          px_d      = '0;
          if (ln_q < V_MAX) ln_d = ln_q + CW'(1);
        end else if (href_r1) begin
          if (href_rise && ln_q >= V_MAX) err_d = 1'b1;
          // The first byte after HREF rises is always the high byte.
          if (href_rise || !hi_pend_q) begin
            hi_byte_d = data_r1;
            hi_pend_d = 1'b1;
          end else begin
            hi_pend_d = 1'b0;
            if (ln_q < V_MAX && px_q < H_MAX) begin
              pix_d   = {hi_byte_q, data_r1};
              x_d     = px_q[COORD_W-1:0];
              y_d     = ln_q[COORD_W-1:0];
              valid_d = 1'b1;
              fs_d    = (px_q == '0) && (ln_q == '0);
              le_d    = (px_q == H_LAST);
              px_d    = px_q + CW'(1);
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_WAIT_CFG;
    endcase
    if (!iCFG_DONE) begin
      state_d   = ST_WAIT_CFG;
      skip_d    = '0;
      hi_pend_d = 1'b0;
      valid_d   = 1'b0;
      fs_d      = 1'b0;
      le_d      = 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= ST_WAIT_CFG;
      skip_q    <= '0;
      vs_seen_q <= 1'b0;
      px_q      <= '0;
      ln_q      <= '0;
      hi_pend_q <= 1'b0;
      hi_byte_q <= '0;
      pix_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      fs_q      <= 1'b0;
      le_q      <= 1'b0;
      err_q     <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      vs_seen_q <= vs_seen_d;
      px_q      <= px_d;
      ln_q      <= ln_d;
      hi_pend_q <= hi_pend_d;
      hi_byte_q <= hi_byte_d;
      pix_q     <= pix_d;
      x_q       <= x_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      fs_q      <= fs_d;
      le_q      <= le_d;
      err_q     <= err_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign oPIX_DATA    = pix_q;
  assign oPIX_VALID   = valid_q;
  assign oX           = x_q;
  assign oY           = y_q;
  assign oFRAME_START = fs_q;
  assign oLINE_END    = le_q;
  assign oFRAME_ERR   = err_q;
  assign oFRAME_CNT   = fcnt_q;
endmodule
